// File: rtl/german_sched_pkg.sv
// german_sched_pkg: shared constants, encodings and LFSR step for the German-protocol rule scheduler.
package german_sched_pkg;
    localparam int NRULES_MAX = 31;
    localparam logic [4:0] NOOP_IDX = 5'h1F;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shift Galois mask for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    typedef enum logic [1:0] {MODE_RR, MODE_FIXED, MODE_LFSR, MODE_RR_ALT} mode_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_DEAD} state_t;
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0);
    endfunction
endpackage

// File: rtl/german_rule_sched_pick.sv
// rule_pick: wrapped find-first-set over N guard bits starting at a given index.
module rule_pick import german_sched_pkg::*; #(
    parameter int N = NRULES_MAX
) (
    input  logic [N-1:0] guard,
    input  logic [4:0]   start,
    output logic [4:0]   idx,
    output logic         found
);
    logic [63:0] dbl;
    logic [5:0]  p;
    // Doubling the guard vector turns the wrapped search into a straight scan
    always_comb begin
        dbl = 64'({guard, guard});
        found = 1'b0;
        idx = NOOP_IDX;
        p = '0;
        for (int k = 0; k < N; k++) begin
            p = 6'(start) + 6'(k);
            if (!found && dbl[p]) begin
                found = 1'b1;
                idx = 5'(p >= 6'(N) ? p - 6'(N) : p);
            end
        end
    end
endmodule

// File: rtl/german_rule_sched.sv
// german_rule_sched: picks one enabled protocol rule per cycle (round-robin, fixed or LFSR)
// with run/step control, deadlock detection and a saturating fire counter.
module german_rule_sched import german_sched_pkg::*; #(
    parameter int NRULES   = 31,
    parameter int DL_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        io_mode,
    input  logic              io_run,
    input  logic              io_step,
    input  logic              io_clear,
    input  logic [NRULES-1:0] io_guard,
    output logic [4:0]        io_en_a,
    output logic              io_fire,
    output logic              io_deadlock,
    output logic [15:0]       io_fire_cnt
);
    localparam int DW = $clog2(DL_LIMIT + 1);
    state_t state, state_nxt;
    mode_t mode;
    logic [4:0] last, start, pick_idx;
    logic [15:0] lfsr;
    logic [DW-1:0] dl_cnt;
    logic found, active, grant, starve, dl_hit;
    assign mode = mode_t'(io_mode);
    rule_pick #(.N(NRULES)) u_pick (
        .guard(io_guard),
        .start(start),
        .idx(pick_idx),
        .found(found)
    );
    always_comb begin
        active = state == S_RUN || state == S_STEP;
        grant = active && found;
        starve = active && !found;
        dl_hit = starve && dl_cnt == DW'(DL_LIMIT - 1);
        start = mode == MODE_FIXED ? 5'd0 :
                mode == MODE_LFSR  ? 5'(lfsr[4:0] % 5'(NRULES)) :
                last == 5'(NRULES - 1) ? 5'd0 : last + 5'd1;
        state_nxt = dl_hit ? S_DEAD :
                    state == S_IDLE ? (io_run ? S_RUN : io_step ? S_STEP : S_IDLE) :
                    state == S_RUN  ? (io_run ? S_RUN : S_IDLE) :
                    state == S_STEP ? (grant ? S_IDLE : S_STEP) :
                    (io_clear ? S_IDLE : S_DEAD);
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_en_a <= NOOP_IDX;
            io_fire <= 1'b0;
            io_deadlock <= 1'b0;
            io_fire_cnt <= '0;
            last <= 5'(NRULES - 1);
            lfsr <= LFSR_SEED;
            dl_cnt <= '0;
        end else begin
            io_en_a <= grant ? pick_idx : NOOP_IDX;
            io_fire <= grant;
            io_deadlock <= state_nxt == S_DEAD;
            lfsr <= lfsr_next(lfsr);
            dl_cnt <= (grant || io_clear) ? '0 : starve ? dl_cnt + DW'(1) : dl_cnt;
            if (grant) begin
                last <= pick_idx;
                io_fire_cnt <= io_fire_cnt + {15'd0, io_fire_cnt != 16'hFFFF};
            end
        end
    end
endmodule
